// File: rtl/qsys_irq_ctrl.sv
// Interrupt aggregator: latches up to 16 sources in edge or level mode and masks them.
// Drives one registered CPU interrupt with priority reporting and a minimum low-time holdoff.
module qsys_irq_ctrl #(
    parameter int NUM_SRC = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    input  logic [NUM_SRC-1:0] irq_in,
    output logic               irq
);

    localparam logic [15:0] SRC_MASK = 16'((17'd1 << NUM_SRC) - 17'd1);

    localparam logic [2:0] ADDR_PENDING = 3'd0;
    localparam logic [2:0] ADDR_ENABLE  = 3'd1;
    localparam logic [2:0] ADDR_MODE    = 3'd2;
    localparam logic [2:0] ADDR_ACTIVE  = 3'd3;
    localparam logic [2:0] ADDR_HOLDOFF = 3'd4;
    localparam logic [2:0] ADDR_RAW     = 3'd5;
    localparam logic [2:0] ADDR_FORCE   = 3'd6;

    logic [15:0] irq_in_w_s;
    logic [15:0] in_q_r;
    logic [15:0] pending_r;
    logic [15:0] enable_r;
    logic [15:0] mode_r;
    logic [15:0] holdoff_r;
    logic [15:0] hold_cnt_r;
    logic [15:0] readdata_r;
    logic        irq_r;

    logic        wr_s;
    logic [15:0] wdata_src_s;
    logic [15:0] rise_s;
    logic [15:0] w1c_s;
    logic [15:0] force_s;
    logic [15:0] pending_nxt_s;
    logic [15:0] act_vec_s;
    logic        act_any_s;
    logic [3:0]  act_idx_s;
    logic        irq_nxt_s;
    logic [15:0] hold_cnt_nxt_s;
    logic [15:0] rd_mux_s;

    // Unused source positions are tied low so all datapaths are uniformly 16 bits wide.
    for (genvar g = 0; g < 16; g++) begin : g_in
        if (g < NUM_SRC) begin : g_used
            assign irq_in_w_s[g] = irq_in[g];
        end else begin : g_unused
            assign irq_in_w_s[g] = 1'b0;
        end
    end

    // Write decode, pending update, priority and irq/holdoff next-state.
    always_comb begin
        wr_s          = chipselect && !write_n;
        wdata_src_s   = writedata & SRC_MASK;
        rise_s        = irq_in_w_s & ~in_q_r;
        w1c_s         = (wr_s && (address == ADDR_PENDING)) ? wdata_src_s : 16'd0;
        force_s       = (wr_s && (address == ADDR_FORCE))   ? wdata_src_s : 16'd0;
        // Edge bits: set (edge or force) beats clear; level bits just mirror the line.
        pending_nxt_s = ((mode_r & (((pending_r & ~w1c_s)) | rise_s | force_s)) |
                         (~mode_r & irq_in_w_s)) & SRC_MASK;

        act_vec_s = pending_r & enable_r;
        act_any_s = |act_vec_s;
        act_idx_s = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            act_idx_s = act_vec_s[i] ? 4'(i) : act_idx_s;
        end

        irq_nxt_s = act_any_s && (hold_cnt_r == 16'd0);
        if (irq_r && !irq_nxt_s) begin
            hold_cnt_nxt_s = holdoff_r;
        end else if (hold_cnt_r != 16'd0) begin
            hold_cnt_nxt_s = hold_cnt_r - 16'd1;
        end else begin
            hold_cnt_nxt_s = hold_cnt_r;
        end

        case (address)
            ADDR_PENDING: rd_mux_s = pending_r;
            ADDR_ENABLE:  rd_mux_s = enable_r;
            ADDR_MODE:    rd_mux_s = mode_r;
            ADDR_ACTIVE:  rd_mux_s = {act_any_s, 11'd0, act_idx_s};
            ADDR_HOLDOFF: rd_mux_s = holdoff_r;
            ADDR_RAW:     rd_mux_s = irq_in_w_s;
            default:      rd_mux_s = 16'd0;
        endcase
    end

    // State, configuration and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_q_r     <= 16'd0;
            pending_r  <= 16'd0;
            enable_r   <= 16'd0;
            mode_r     <= 16'd0;
            holdoff_r  <= 16'd0;
            hold_cnt_r <= 16'd0;
            readdata_r <= 16'd0;
            irq_r      <= 1'b0;
        end else begin
            in_q_r     <= irq_in_w_s;
            pending_r  <= pending_nxt_s;
            hold_cnt_r <= hold_cnt_nxt_s;
            readdata_r <= rd_mux_s;
            irq_r      <= irq_nxt_s;
            if (wr_s && (address == ADDR_ENABLE)) begin
                enable_r <= wdata_src_s;
            end else begin
                enable_r <= enable_r;
            end
            if (wr_s && (address == ADDR_MODE)) begin
                mode_r <= wdata_src_s;
            end else begin
                mode_r <= mode_r;
            end
            if (wr_s && (address == ADDR_HOLDOFF)) begin
                holdoff_r <= writedata;
            end else begin
                holdoff_r <= holdoff_r;
            end
        end
    end

    assign readdata = readdata_r;
    assign irq      = irq_r;

endmodule

// File: tb/tb_qsys_irq_ctrl.sv
// Bench for qsys_irq_ctrl: directed and random register/irq traffic checked against a
// behavioural model through an expected-response queue.
module tb_qsys_irq_ctrl;

    localparam int NUM_SRC = 4;
    localparam logic [15:0] SMASK = 16'h000F;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [2:0]         address = 3'd0;
    logic               chipselect = 1'b0;
    logic               write_n = 1'b1;
    logic [15:0]        writedata = 16'd0;
    logic [15:0]        readdata;
    logic [NUM_SRC-1:0] irq_in = '0;
    logic               irq;

    int n_checks = 0;
    int n_errors = 0;

    qsys_irq_ctrl #(.NUM_SRC(NUM_SRC)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .irq_in(irq_in), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [15:0] m_pend, m_en, m_mode, m_hold, m_prev;
    int          m_cnt;
    logic        m_irq;
    logic [16:0] exp_q[$];

    function automatic logic [15:0] m_read(input logic [2:0] a, input logic [15:0] raw);
        logic [15:0] act;
        act = m_pend & m_en;
        case (a)
            3'd0: return m_pend;
            3'd1: return m_en;
            3'd2: return m_mode;
            3'd3: begin
                for (int i = 0; i < NUM_SRC; i++)
                    if (act[i]) return 16'h8000 | 16'(i);
                return 16'h0000;
            end
            3'd4: return m_hold;
            3'd5: return raw;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic m_reset();
        m_pend = 16'd0; m_en = 16'd0; m_mode = 16'd0; m_hold = 16'd0;
        m_prev = 16'd0; m_cnt = 0; m_irq = 1'b0;
    endtask

    always @(negedge reset_n) m_reset();

    // Model advance at each clock edge, pushing the expected post-edge outputs
    always @(posedge clk) begin
        logic [15:0] raw, rd, np;
        logic        wr, irq_n;
        if (!reset_n) begin
            m_reset();
            exp_q.push_back(17'd0);
        end else begin
            raw   = 16'(irq_in);
            wr    = chipselect && !write_n;
            rd    = m_read(address, raw);
            irq_n = ((m_pend & m_en) != 16'd0) && (m_cnt == 0);
            if (m_irq && !irq_n) m_cnt = int'(m_hold);
            else if (m_cnt > 0)  m_cnt = m_cnt - 1;
            np = m_pend;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (m_mode[i]) begin
                    if ((raw[i] && !m_prev[i]) || (wr && address == 3'd6 && writedata[i]))
                        np[i] = 1'b1;
                    else if (wr && address == 3'd0 && writedata[i])
                        np[i] = 1'b0;
                end else begin
                    np[i] = raw[i];
                end
            end
            m_pend = np;
            if (wr && address == 3'd1) m_en   = writedata & SMASK;
            if (wr && address == 3'd2) m_mode = writedata & SMASK;
            if (wr && address == 3'd4) m_hold = writedata;
            m_prev = raw;
            m_irq  = irq_n;
            exp_q.push_back({rd, irq_n});
        end
    end

    // Monitor: DUT outputs are presented every cycle; compare just after the edge
    always @(posedge clk) begin
        logic [16:0] e;
        #1;
        if (exp_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL scoreboard_empty at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            n_checks += 2;
            if (readdata !== e[16:1]) begin
                n_errors++;
                $display("FAIL readdata at %0t addr=%0d got=%04h exp=%04h", $time, address, readdata, e[16:1]);
            end
            if (irq !== e[0]) begin
                n_errors++;
                $display("FAIL irq at %0t got=%b exp=%b", $time, irq, e[0]);
            end
        end
    end

    task automatic step(input logic [2:0] a, input logic cs, input logic wn, input logic [15:0] wd);
        address = a; chipselect = cs; write_n = wn; writedata = wd;
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] wd);
        step(a, 1'b1, 1'b0, wd);
    endtask

    task automatic rd(input logic [2:0] a, input int n);
        for (int i = 0; i < n; i++) step(a, 1'b0, 1'b1, 16'd0);
    endtask

    initial begin
        @(negedge clk); @(negedge clk); @(negedge clk);
        reset_n = 1'b1;

        // Edge latch and clear
        wr(3'd2, 16'h0001); wr(3'd1, 16'h0001);
        irq_in = 4'b0001; rd(3'd0, 1);
        irq_in = 4'b0000; rd(3'd0, 3); rd(3'd3, 2);
        wr(3'd0, 16'h0001); rd(3'd0, 3);

        // Level mode
        wr(3'd2, 16'h0000); wr(3'd1, 16'h0002);
        irq_in = 4'b0010; rd(3'd3, 3);
        wr(3'd0, 16'h0002); rd(3'd0, 2);
        irq_in = 4'b0000; rd(3'd0, 3);

        // Priority and mask
        wr(3'd2, 16'h000F); wr(3'd1, 16'h000C); wr(3'd0, 16'h000F);
        irq_in = 4'b1110; rd(3'd0, 1);
        irq_in = 4'b0000; rd(3'd0, 2); rd(3'd3, 2);
        wr(3'd0, 16'h0004); rd(3'd3, 2);

        // Set/clear collision
        wr(3'd0, 16'h000F); rd(3'd0, 1);
        irq_in = 4'b0001; wr(3'd0, 16'h0001);
        irq_in = 4'b0000; rd(3'd0, 2);

        // Holdoff 5 then 0
        for (int h = 0; h < 2; h++) begin
            wr(3'd4, (h == 0) ? 16'd5 : 16'd0);
            wr(3'd1, 16'h0001); wr(3'd0, 16'h000F);
            irq_in = 4'b0001; rd(3'd3, 1); irq_in = 4'b0000; rd(3'd3, 2);
            wr(3'd0, 16'h0001);
            rd(3'd4, 1);
            irq_in = 4'b0001; rd(3'd4, 1); irq_in = 4'b0000; rd(3'd0, 9);
            wr(3'd0, 16'h0001); rd(3'd0, 2);
        end

        // Async reset mid-countdown with source 0 high
        wr(3'd4, 16'd20);
        irq_in = 4'b0001; rd(3'd0, 1); irq_in = 4'b0000; rd(3'd0, 2);
        wr(3'd0, 16'h0001); irq_in = 4'b0001; rd(3'd4, 3);
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        n_checks += 2;
        if (readdata !== 16'd0) begin
            n_errors++; $display("FAIL reset_readdata got=%04h exp=0000", readdata);
        end
        if (irq !== 1'b0) begin
            n_errors++; $display("FAIL reset_irq got=%b exp=0", irq);
        end
        @(negedge clk); rd(3'd0, 2);
        reset_n = 1'b1;
        rd(3'd0, 2);
        wr(3'd1, 16'h0001); rd(3'd3, 2);
        irq_in = 4'b0000; rd(3'd0, 3);
        irq_in = 4'b0001; rd(3'd2, 3);
        irq_in = 4'b0000;

        // FORCE in level mode vs edge mode
        wr(3'd6, 16'h0001); rd(3'd0, 2); rd(3'd6, 1);
        wr(3'd2, 16'h0001); wr(3'd6, 16'h0001); rd(3'd0, 3);

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            logic [2:0]  a;
            logic [15:0] d;
            a = 3'($urandom_range(0, 7));
            d = 16'($urandom);
            if (a == 3'd4) d = d & 16'h0007;
            irq_in = 4'($urandom);
            if ($urandom_range(0, 2) == 0) wr(a, d);
            else step(a, 1'($urandom_range(0, 1)), 1'b1, d);
        end
        irq_in = 4'b0000;
        rd(3'd0, 2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
